// File: rtl/step_sequencer.sv
// Instruction step sequencer: walks each instruction through EXEC, optional read/write waits and RETIRE.
// Latency: plain 2 cycles, +RD_WAIT for reads, +WR_WAIT for writes; strobes are combinational from state.
// Backpressure: none; the step button, run_mode and halt gate progress only at instruction boundaries.
module step_sequencer #(
  parameter int            IW      = 16,
  parameter int            RD_WAIT = 1,
  parameter int            WR_WAIT = 1,
  parameter logic [IW-1:0] HALT_OP = 16'h0300,
  parameter int            CNT_W   = 16
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             user_clock,
  input  logic             run_mode,
  input  logic             clock_lock,
  input  logic [IW-1:0]    instruction,
  input  logic             needs_read,
  input  logic             needs_write,
  input  logic [1:0]       load_src_in,
  output logic [2:0]       state,
  output logic             pc_increment,
  output logic [1:0]       load_src,
  output logic             write_strobe,
  output logic             switch_clock,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    ST_STOPPED = 3'd0,
    ST_ARMED   = 3'd1,
    ST_EXEC    = 3'd2,
    ST_WAIT_RD = 3'd3,
    ST_WAIT_WR = 3'd4,
    ST_RETIRE  = 3'd5
  } state_t;

  // Wait counters are loaded with (cycles - 1) so that zero marks the final wait cycle.
  localparam logic [3:0] RD_LOAD = 4'(RD_WAIT - 1);
  localparam logic [3:0] WR_LOAD = 4'(WR_WAIT - 1);

  state_t     state_q;
  state_t     state_d;
  logic [3:0] wait_q;
  logic [3:0] wait_d;
  logic       last_wait;
  logic       halt;
  logic       pc_inc_c;
  logic       wr_stb_c;

  // Halt is either an external lock or the halt opcode; it only takes effect at RETIRE.
  assign halt         = clock_lock | (instruction == HALT_OP);
  assign switch_clock = halt;
  assign last_wait    = (wait_q == 4'd0);
  assign state        = state_q;

  // A cycle in which reset is asserted commits nothing, even if the state would strobe.
  assign pc_increment = pc_inc_c & resetn;
  assign write_strobe = wr_stb_c & resetn;
  assign load_src     = pc_increment ? load_src_in : 2'b00;

  // Next-state, wait counter and strobe decode.
  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    pc_inc_c = 1'b0;
    wr_stb_c = 1'b0;
    case (state_q)
      ST_STOPPED: begin
        // Require a button release before arming so one press equals one step.
        if (!user_clock) begin
          state_d = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (user_clock) begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (needs_read) begin
          state_d = ST_WAIT_RD;
          wait_d  = RD_LOAD;
        end else if (needs_write) begin
          state_d = ST_WAIT_WR;
          wait_d  = WR_LOAD;
        end else begin
          state_d  = ST_RETIRE;
          pc_inc_c = 1'b1;
        end
      end
      ST_WAIT_RD: begin
        if (last_wait) begin
          if (needs_write) begin
            state_d = ST_WAIT_WR;
            wait_d  = WR_LOAD;
          end else begin
            state_d  = ST_RETIRE;
            pc_inc_c = 1'b1;
          end
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      ST_WAIT_WR: begin
        if (last_wait) begin
          state_d  = ST_RETIRE;
          pc_inc_c = 1'b1;
          wr_stb_c = 1'b1;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      ST_RETIRE: begin
        // Only here are halt and run_mode sampled, so a running instruction always completes.
        if (halt || !run_mode) begin
          state_d = ST_STOPPED;
        end else begin
          state_d = ST_EXEC;
        end
      end
      default: begin
        state_d = ST_STOPPED;
        wait_d  = 4'd0;
      end
    endcase
  end

  // State, wait counter and retired-instruction counter registers.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= ST_STOPPED;
      wait_q  <= 4'd0;
      retired <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      retired <= retired + CNT_W'(pc_increment);
    end
  end

endmodule

// File: tb/tb_step_sequencer.sv
// Self-checking bench for step_sequencer with RD_WAIT=3, WR_WAIT=2, CNT_W=4.
// Expected per-cycle behaviour is derived from instruction shape (read/write) and cycle index.
// Inputs are driven 1 time unit after the rising edge, outputs sampled on the falling edge.
module tb_step_sequencer;

  localparam int          RDW  = 3;
  localparam int          WRW  = 2;
  localparam logic [15:0] HALT = 16'h0300;

  logic        clock;
  logic        resetn;
  logic        user_clock;
  logic        run_mode;
  logic        clock_lock;
  logic [15:0] instruction;
  logic        needs_read;
  logic        needs_write;
  logic [1:0]  load_src_in;
  logic [2:0]  state;
  logic        pc_increment;
  logic [1:0]  load_src;
  logic        write_strobe;
  logic        switch_clock;
  logic [3:0]  retired;

  int checks = 0;
  int errors = 0;
  int exp_ret = 0;

  step_sequencer #(
    .IW(16), .RD_WAIT(RDW), .WR_WAIT(WRW), .HALT_OP(HALT), .CNT_W(4)
  ) dut (
    .clock(clock), .resetn(resetn), .user_clock(user_clock), .run_mode(run_mode),
    .clock_lock(clock_lock), .instruction(instruction), .needs_read(needs_read),
    .needs_write(needs_write), .load_src_in(load_src_in), .state(state),
    .pc_increment(pc_increment), .load_src(load_src), .write_strobe(write_strobe),
    .switch_clock(switch_clock), .retired(retired)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [15:0] rand_plain();
    logic [15:0] v;
    v = 16'($urandom);
    if (v == HALT) v = 16'h0301;
    return v;
  endfunction

  task automatic do_reset();
    resetn = 1'b0;
    tick();
    tick();
    resetn  = 1'b1;
    exp_ret = 0;
  endtask

  // From STOPPED: release then press the step button, leaving the DUT in EXEC.
  task automatic arm_and_go();
    user_clock = 1'b0;
    tick();
    user_clock = 1'b1;
    tick();
  endtask

  // Runs one instruction from its EXEC cycle through RETIRE, checking every cycle.
  // lock_at >= 0 raises clock_lock at that cycle index of the instruction.
  task automatic exec_instr(input logic nr, input logic nw, input logic [1:0] ls,
                            input logic [15:0] ins, input int lock_at, input string tag);
    int   rd_c;
    int   len;
    logic [2:0] e_state;
    logic e_pc;
    logic e_ws;
    logic [1:0] e_ls;
    logic e_sw;
    rd_c = nr ? RDW : 0;
    len  = 2 + rd_c + (nw ? WRW : 0);
    needs_read  = nr;
    needs_write = nw;
    load_src_in = ls;
    instruction = ins;
    for (int k = 0; k < len; k++) begin
      if (k == lock_at) clock_lock = 1'b1;
      @(negedge clock);
      if (k == 0)             e_state = 3'd2;
      else if (k < 1 + rd_c)  e_state = 3'd3;
      else if (k < len - 1)   e_state = 3'd4;
      else                    e_state = 3'd5;
      e_pc = (k == len - 2);
      e_ws = nw && (k == len - 2);
      e_ls = e_pc ? ls : 2'b00;
      e_sw = clock_lock | (ins == HALT);
      checks++;
      if (state !== e_state) begin
        errors++; $display("FAIL %s state k=%0d got %0d want %0d", tag, k, state, e_state);
      end
      checks++;
      if (pc_increment !== e_pc) begin
        errors++; $display("FAIL %s pc_increment k=%0d got %b want %b", tag, k, pc_increment, e_pc);
      end
      checks++;
      if (write_strobe !== e_ws) begin
        errors++; $display("FAIL %s write_strobe k=%0d got %b want %b", tag, k, write_strobe, e_ws);
      end
      checks++;
      if (load_src !== e_ls) begin
        errors++; $display("FAIL %s load_src k=%0d got %0d want %0d", tag, k, load_src, e_ls);
      end
      checks++;
      if (switch_clock !== e_sw) begin
        errors++; $display("FAIL %s switch_clock k=%0d got %b want %b", tag, k, switch_clock, e_sw);
      end
      checks++;
      if (retired !== 4'(exp_ret)) begin
        errors++; $display("FAIL %s retired k=%0d got %0d want %0d", tag, k, retired, exp_ret);
      end
      @(posedge clock);
      if (e_pc) exp_ret = (exp_ret + 1) % 16;
      #1;
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0; user_clock = 1'b1; run_mode = 1'b0; clock_lock = 1'b0;
    instruction = 16'h0000; needs_read = 1'b0; needs_write = 1'b0; load_src_in = 2'b11;
    tick(); tick();
    @(negedge clock);
    checks++;
    if (state !== 3'd0) begin errors++; $display("FAIL reset state got %0d want 0", state); end
    checks++;
    if (retired !== 4'd0) begin errors++; $display("FAIL reset retired got %0d want 0", retired); end
    checks++;
    if ({pc_increment, write_strobe, load_src} !== 4'b0000) begin
      errors++; $display("FAIL reset strobes got %b%b%b want 0000", pc_increment, write_strobe, load_src);
    end
    checks++;
    if (switch_clock !== 1'b0) begin errors++; $display("FAIL reset switch_clock got %b want 0", switch_clock); end
    clock_lock = 1'b1; #1;
    checks++;
    if (switch_clock !== 1'b1) begin errors++; $display("FAIL lock switch_clock got %b want 1", switch_clock); end
    clock_lock = 1'b0; instruction = HALT; #1;
    checks++;
    if (switch_clock !== 1'b1) begin errors++; $display("FAIL haltop switch_clock got %b want 1", switch_clock); end
    instruction = 16'h0000;
    resetn = 1'b1; exp_ret = 0;
    tick();
    @(negedge clock);
    checks++;
    if (state !== 3'd0) begin errors++; $display("FAIL held_button state got %0d want 0", state); end
  endtask

  task automatic test_step_mode();
    run_mode   = 1'b0;
    user_clock = 1'b0;
    tick();
    @(negedge clock);
    checks++;
    if (state !== 3'd1) begin errors++; $display("FAIL step armed state got %0d want 1", state); end
    user_clock = 1'b1;
    tick();
    exec_instr(1'b0, 1'b0, 2'($urandom), rand_plain(), -1, "step");
    @(negedge clock);
    checks++;
    if (state !== 3'd0) begin errors++; $display("FAIL step end state got %0d want 0", state); end
    checks++;
    if (retired !== 4'd1) begin errors++; $display("FAIL step retired got %0d want 1", retired); end
  endtask

  task automatic test_rmw();
    run_mode = 1'b0;
    arm_and_go();
    exec_instr(1'b1, 1'b1, 2'd2, rand_plain(), -1, "rmw");
    @(negedge clock);
    checks++;
    if (state !== 3'd0) begin errors++; $display("FAIL rmw end state got %0d want 0", state); end
  endtask

  task automatic test_run_halt();
    do_reset();
    run_mode = 1'b1;
    arm_and_go();
    for (int i = 0; i < 3; i++)
      exec_instr(1'($urandom), 1'($urandom), 2'($urandom), rand_plain(), -1, "run");
    exec_instr(1'($urandom), 1'($urandom), 2'($urandom), HALT, -1, "halt");
    @(negedge clock);
    checks++;
    if (state !== 3'd0) begin errors++; $display("FAIL halt end state got %0d want 0", state); end
    checks++;
    if (retired !== 4'd4) begin errors++; $display("FAIL halt retired got %0d want 4", retired); end
    checks++;
    if (switch_clock !== 1'b1) begin errors++; $display("FAIL halt switch_clock got %b want 1", switch_clock); end
    instruction = 16'h0000;
  endtask

  task automatic test_clock_lock();
    run_mode = 1'b1;
    arm_and_go();
    exec_instr(1'b1, 1'b0, 2'd1, rand_plain(), 2, "lock");
    @(negedge clock);
    checks++;
    if (state !== 3'd0) begin errors++; $display("FAIL lock end state got %0d want 0", state); end
    clock_lock = 1'b0;
  endtask

  task automatic test_reset_mid_wait();
    run_mode = 1'b1;
    arm_and_go();
    needs_read = 1'b0; needs_write = 1'b1; load_src_in = 2'd3; instruction = rand_plain();
    tick();
    @(negedge clock);
    checks++;
    if (state !== 3'd4) begin errors++; $display("FAIL rstwait first state got %0d want 4", state); end
    tick();
    resetn = 1'b0;
    @(negedge clock);
    checks++;
    if (state !== 3'd4) begin errors++; $display("FAIL rstwait second state got %0d want 4", state); end
    checks++;
    if ({write_strobe, pc_increment} !== 2'b00) begin
      errors++; $display("FAIL rstwait strobes got %b%b want 00", write_strobe, pc_increment);
    end
    tick();
    @(negedge clock);
    checks++;
    if (state !== 3'd0) begin errors++; $display("FAIL rstwait state got %0d want 0", state); end
    checks++;
    if (retired !== 4'd0) begin errors++; $display("FAIL rstwait retired got %0d want 0", retired); end
    resetn  = 1'b1;
    exp_ret = 0;
  endtask

  task automatic test_wrap();
    do_reset();
    run_mode = 1'b1;
    arm_and_go();
    for (int i = 0; i < 16; i++) begin
      if (i == 15) run_mode = 1'b0;
      exec_instr(1'b0, 1'b0, 2'($urandom), rand_plain(), -1, "wrap");
    end
    @(negedge clock);
    checks++;
    if (retired !== 4'd0) begin errors++; $display("FAIL wrap retired got %0d want 0", retired); end
    checks++;
    if (state !== 3'd0) begin errors++; $display("FAIL wrap end state got %0d want 0", state); end
  endtask

  task automatic test_random();
    run_mode = 1'b1;
    arm_and_go();
    for (int i = 0; i < 12; i++) begin
      if (i == 11) run_mode = 1'b0;
      exec_instr(1'($urandom), 1'($urandom), 2'($urandom), rand_plain(), -1, "rand");
    end
    @(negedge clock);
    checks++;
    if (state !== 3'd0) begin errors++; $display("FAIL rand end state got %0d want 0", state); end
  endtask

  initial begin
    test_reset();
    test_step_mode();
    test_rmw();
    test_run_halt();
    test_clock_lock();
    test_reset_mid_wait();
    test_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/step_sequencer.md
STEP_SEQUENCER -- requirements
Module: step_sequencer

Interface
REQ-001 SHALL have parameter IW, default 16, instruction width.
REQ-002 SHALL have parameter RD_WAIT, default 1, read-wait cycles (legal range 1..15).
REQ-003 SHALL have parameter WR_WAIT, default 1, write-wait cycles (legal range 1..15).
REQ-004 SHALL have parameter HALT_OP, default 16'h0300, halt instruction encoding (IW bits).
REQ-005 SHALL have parameter CNT_W, default 16, retired-counter width.
REQ-006 SHALL have port clock, input, 1, rising-edge system clock.
REQ-007 SHALL have port resetn, input, 1, reset, synchronous, active-low.
REQ-008 SHALL have port user_clock, input, 1, step button level, 1 = pressed.
REQ-009 SHALL have port run_mode, input, 1, 1 = free-run, 0 = single-step.
REQ-010 SHALL have port clock_lock, input, 1, external stop request.
REQ-011 SHALL have port instruction, input, IW, current instruction.
REQ-012 SHALL have port needs_read, input, 1, decoder: instruction loads from memory/stack.
REQ-013 SHALL have port needs_write, input, 1, decoder: instruction stores to memory/stack.
REQ-014 SHALL have port load_src_in, input, 2, decoder load source (self/alu/mem/stk).
REQ-015 SHALL have port state, output, 3, current state encoding.
REQ-016 SHALL have port pc_increment, output, 1, single-cycle program-counter advance.
REQ-017 SHALL have port load_src, output, 2, gated register load source.
REQ-018 SHALL have port write_strobe, output, 1, single-cycle store commit.
REQ-019 SHALL have port switch_clock, output, 1, stop indication.
REQ-020 SHALL have port retired, output, CNT_W, count of retired instructions.

Function
REQ-021 SHALL encode states STOPPED=0, ARMED=1, EXEC=2, WAIT_RD=3, WAIT_WR=4, RETIRE=5; state registered on rising clock edge.
REQ-022 SHALL define halt = clock_lock | (instruction == HALT_OP); switch_clock = halt, combinational, in every state.
REQ-023 SHALL transition STOPPED: user_clock=0 -> ARMED; else stay STOPPED.
REQ-024 SHALL transition ARMED: user_clock=1 -> EXEC; else stay ARMED.
REQ-025 SHALL transition EXEC: needs_read -> WAIT_RD; else needs_write -> WAIT_WR; else RETIRE.
REQ-026 SHALL hold WAIT_RD exactly RD_WAIT cycles (down-counter loaded RD_WAIT-1 on entry); on last cycle: needs_write -> WAIT_WR, else RETIRE.
REQ-027 SHALL hold WAIT_WR exactly WR_WAIT cycles (counter loaded WR_WAIT-1 on entry); on last cycle -> RETIRE.
REQ-028 SHALL transition RETIRE: halt=1 or run_mode=0 -> STOPPED; else -> EXEC.
REQ-029 SHALL transition from illegal encodings 6/7 -> STOPPED next cycle, all strobes 0 meanwhile.
REQ-030 SHALL assert pc_increment, combinationally, for exactly one cycle per instruction: in EXEC if neither needs_read nor needs_write; last WAIT_RD cycle if needs_write=0; last WAIT_WR cycle.
REQ-031 SHALL drive load_src = load_src_in in the pc_increment cycle, 2'b00 in every other cycle.
REQ-032 SHALL assert write_strobe only in the last WAIT_WR cycle.
REQ-033 SHALL increment retired by 1 on each edge where pc_increment=1, wrapping from all-ones to 0.
REQ-034 SHALL sample halt and run_mode only in RETIRE; clock_lock asserted mid-instruction SHALL NOT abort it.
REQ-035 SHALL treat needs_read, needs_write, load_src_in as stable from EXEC through the retiring cycle (upstream guarantee), no internal latching.
REQ-036 SHALL give instruction latency: plain 2 cycles (EXEC, RETIRE); read 2+RD_WAIT; write 2+WR_WAIT; read+write 2+RD_WAIT+WR_WAIT.

Reset
REQ-037 SHALL, on an edge with resetn=0, set state=STOPPED, wait counter=0, retired=0, regardless of current state, including mid-wait.
REQ-038 SHALL, while in STOPPED, drive pc_increment=0, write_strobe=0, load_src=2'b00; switch_clock follows halt.

Verification
REQ-039 SHALL verify step mode: run_mode=0, user_clock 1->0->1, plain instruction -> states 0,1,2,5,0; one pc_increment pulse in EXEC; retired=1.
REQ-040 SHALL verify read-modify-write: RD_WAIT=3, WR_WAIT=2, needs_read=needs_write=1, load_src_in=2 -> 3 WAIT_RD cycles, 2 WAIT_WR cycles; pc_increment, write_strobe, load_src=2 together in last WAIT_WR cycle only.
REQ-041 SHALL verify run mode with halt: run_mode=1, three plain instructions then instruction=16'h0300 -> retired=4, state returns to STOPPED after RETIRE, switch_clock=1.
REQ-042 SHALL verify clock_lock asserted during WAIT_RD -> instruction completes (pc_increment pulse), then STOPPED.
REQ-043 SHALL verify resetn=0 in second WAIT_WR cycle -> next edge state=0, retired=0, no write_strobe.
REQ-044 SHALL verify counter wrap: CNT_W=4, 16 plain retires in run mode -> retired 15 -> 0.
